rv32_m_arbiter: RTL

Shares one external RV32M multiply/divide unit between N_PORTS execution-stage requesters, e.g. harts or cores in a multi-core build with `__RV32_M_EXTERNAL`. It accepts level-held requests, picks one round-robin, and drives a single 0→1 enable pulse with latched operands to the unit. It waits for the unit's acknowledge, then returns the registered result with a one-cycle acknowledge to the granted requester. It sits between the ex stages and the shared M unit.

---
 rtl/rv32_m_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/rv32_m_arbiter.sv
// Round-robin arbiter that shares one external RV32M multiply/divide unit among N_PORTS requesters.
// Every output comes from a flop. The unit sees exactly one o_m_en pulse for each granted request.
module rv32_m_arbiter #(
  parameter int N_PORTS = 2,
  parameter int XLEN    = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_PORTS-1:0]      i_req_en,
  input  logic [N_PORTS*XLEN-1:0] i_req_rs1,
  input  logic [N_PORTS*XLEN-1:0] i_req_rs2,
  input  logic [N_PORTS*3-1:0]    i_req_f3,
  output logic [N_PORTS-1:0]      o_req_ack,
  output logic [XLEN-1:0]         o_req_res,
  output logic                    o_m_en,
  output logic [XLEN-1:0]         o_m_rs1,
  output logic [XLEN-1:0]         o_m_rs2,
  output logic [2:0]              o_m_f3,
  input  logic                    i_m_ack,
  input  logic [XLEN-1:0]         i_m_res,
  output logic                    o_busy
);
  localparam int IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_nx;

  logic [IW-1:0]   rr_ptr, grant, pick, cand;
  logic            pick_vld;
  logic [XLEN-1:0] rs1_a [N_PORTS];
  logic [XLEN-1:0] rs2_a [N_PORTS];
  logic [2:0]      f3_a  [N_PORTS];

  for (genvar p = 0; p < N_PORTS; p++) begin : g_unpack
    assign rs1_a[p] = i_req_rs1[p*XLEN +: XLEN];
    assign rs2_a[p] = i_req_rs2[p*XLEN +: XLEN];
    assign f3_a[p]  = i_req_f3[p*3 +: 3];
  end

  // The search starts at rr_ptr and takes the first port that is requesting.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so that no path can infer a latch.
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      cand = IW'((int'(rr_ptr) + k) % N_PORTS);
      if (!pick_vld && i_req_en[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_vld) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      // If the requester has flushed, the result is dropped and no ack is sent.
      WAIT:    if (i_m_ack) state_nx = i_req_en[grant] ? DONE : IDLE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (!i_rst) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rr_ptr    <= '0;
      grant     <= '0;
      o_m_en    <= 1'b0;
      o_m_rs1   <= '0;
      o_m_rs2   <= '0;
      o_m_f3    <= '0;
      o_req_ack <= '0;
      o_req_res <= '0;
      o_busy    <= 1'b0;
    end else begin
      o_m_en    <= (state_nx == ISSUE);
      o_busy    <= (state_nx != IDLE);
      o_req_ack <= '0;
      if (state == IDLE && pick_vld) begin
        grant   <= pick;
        o_m_rs1 <= rs1_a[pick];
        o_m_rs2 <= rs2_a[pick];
        o_m_f3  <= f3_a[pick];
      end
      if (state == WAIT && i_m_ack && i_req_en[grant]) begin
        o_req_res <= i_m_res;
        o_req_ack <= N_PORTS'(1) << grant;
      end
      if (state == DONE)
        rr_ptr <= (grant == IW'(N_PORTS - 1)) ? '0 : grant + 1'b1;
    end
  end

endmodule
